dma_bus_arbiter: RTL and testbench

- Arbitrates the single shared memory bus between the pipelined CPU (instruction fetch and LWD/SWD) and the DMA engine.
- Implements the BR/BG handshake with cycle stealing at CPU transaction boundaries.
- Gives the CPU priority for one contention after each DMA burst, and bounds DMA bus hold time.
- Its stall output feeds the pipeline controller's IF/MEM hazard inputs.

---
 rtl/dma_bus_arbiter.sv | 126 ++++++++++++
 tb/tb_dma_bus_arbiter.sv | 199 +++++++++++++++++++
 2 files changed

// File: rtl/dma_bus_arbiter.sv
// Shared memory bus arbiter between the pipelined CPU and the DMA engine.
// BR/BG handshake with cycle stealing at CPU transaction boundaries. The CPU
// gets priority for one contention after each DMA burst. DMA hold time is
// bounded by a watchdog that forces release and raises a sticky error flag.
module dma_bus_arbiter #(
  parameter int MAX_HOLD = 8,
  parameter int HOLD_W   = 4
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       cpu_mem_req,
  input  logic       cpu_mem_busy,
  input  logic       dma_br,
  input  logic       dma_burst_done,
  input  logic       dma_all_done,
  output logic       bg,
  output logic       cpu_grant,
  output logic       cpu_bus_stall,
  output logic       dma_done_irq,
  output logic       timeout_err,
  output logic [1:0] bus_owner
);

  typedef enum logic [1:0] {
    IDLE        = 2'd0,
    CPU_ACCESS  = 2'd1,
    DMA_GRANT   = 2'd2,
    DMA_RELEASE = 2'd3
  } state_e;

  localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(MAX_HOLD - 1);

  state_e            state_q, state_d;
  logic [HOLD_W-1:0] hold_q, hold_d;
  logic              cpu_prio_q, cpu_prio_d;
  logic              irq_pend_q, irq_pend_d;
  logic              terr_q, terr_d;
  logic              bg_q, irq_q;
  logic              grant_c;

  // Next-state, bookkeeping and combinational CPU grant.
  always_comb begin
    state_d    = state_q;
    hold_d     = '0;
    cpu_prio_d = cpu_prio_q;
    irq_pend_d = irq_pend_q;
    terr_d     = terr_q;
    grant_c    = 1'b0;
    case (state_q)
      IDLE: begin
        if (cpu_mem_req && cpu_prio_q) begin
          grant_c    = 1'b1;
          state_d    = CPU_ACCESS;
          cpu_prio_d = 1'b0;
        end else if (dma_br) begin
          state_d = DMA_GRANT;
        end else if (cpu_mem_req) begin
          grant_c = 1'b1;
          state_d = CPU_ACCESS;
        end else begin
          cpu_prio_d = 1'b0;
        end
      end
      CPU_ACCESS: begin
        grant_c = 1'b1;
        // The bus is only stolen between CPU transactions.
        if (!cpu_mem_busy) begin
          if (dma_br)            state_d = DMA_GRANT;
          else if (!cpu_mem_req) state_d = IDLE;
        end
      end
      DMA_GRANT: begin
        hold_d = hold_q + 1'b1;
        if (dma_all_done) irq_pend_d = 1'b1;
        // A burst_done in the watchdog's last cycle is a clean finish.
        if (dma_burst_done) begin
          state_d = DMA_RELEASE;
        end else if (hold_q == HOLD_LAST) begin
          terr_d  = 1'b1;
          state_d = DMA_RELEASE;
        end else if (!dma_br) begin
          state_d = DMA_RELEASE;
        end
      end
      DMA_RELEASE: begin
        cpu_prio_d = 1'b1;
        irq_pend_d = 1'b0;
        state_d    = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // State and registered outputs; bg and irq are computed from the next state
  // so they line up with the cycle the arbiter is in that state.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q    <= IDLE;
      hold_q     <= '0;
      cpu_prio_q <= 1'b0;
      irq_pend_q <= 1'b0;
      terr_q     <= 1'b0;
      bg_q       <= 1'b0;
      irq_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      hold_q     <= hold_d;
      cpu_prio_q <= cpu_prio_d;
      irq_pend_q <= irq_pend_d;
      terr_q     <= terr_d;
      bg_q       <= (state_d == DMA_GRANT);
      irq_q      <= (state_d == DMA_RELEASE) && irq_pend_d;
    end
  end

  assign bg            = bg_q;
  assign cpu_grant     = grant_c;
  assign cpu_bus_stall = cpu_mem_req && !grant_c;
  assign dma_done_irq  = irq_q;
  assign timeout_err   = terr_q;
  assign bus_owner     = state_q;

  // The bus never has two masters.
  a_one_master: assert property (@(posedge clk) disable iff (!reset_n) !(bg && cpu_grant));

endmodule

// File: tb/tb_dma_bus_arbiter.sv
module tb_dma_bus_arbiter;
  localparam int MAX_HOLD = 8;

  logic clk = 1'b0;
  logic reset_n, cpu_mem_req, cpu_mem_busy, dma_br, dma_burst_done, dma_all_done;
  logic bg, cpu_grant, cpu_bus_stall, dma_done_irq, timeout_err;
  logic [1:0] bus_owner;

  dma_bus_arbiter #(.MAX_HOLD(MAX_HOLD), .HOLD_W(4)) dut (
    .clk(clk), .reset_n(reset_n), .cpu_mem_req(cpu_mem_req), .cpu_mem_busy(cpu_mem_busy),
    .dma_br(dma_br), .dma_burst_done(dma_burst_done), .dma_all_done(dma_all_done),
    .bg(bg), .cpu_grant(cpu_grant), .cpu_bus_stall(cpu_bus_stall),
    .dma_done_irq(dma_done_irq), .timeout_err(timeout_err), .bus_owner(bus_owner));

  always #5 clk = ~clk;

  typedef struct {
    int bg, cg, stall, irq, terr, owner;
  } exp_t;
  exp_t sb[$];

  int checks = 0, failures = 0;

  task automatic chk(string name, int act, int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s actual=%0d expected=%0d at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor: compare DUT outputs mid-cycle against the oldest expectation.
  always @(negedge clk) begin
    if (sb.size() > 0) begin
      exp_t e;
      e = sb.pop_front();
      chk("bg", int'(bg), e.bg);
      chk("cpu_grant", int'(cpu_grant), e.cg);
      chk("cpu_bus_stall", int'(cpu_bus_stall), e.stall);
      chk("dma_done_irq", int'(dma_done_irq), e.irq);
      chk("timeout_err", int'(timeout_err), e.terr);
      chk("bus_owner", int'(bus_owner), e.owner);
    end
  end

  // Reference model: who holds the bus, how long DMA has held it,
  // whether the CPU is owed a turn, and interrupt/error bookkeeping.
  int  m_owner = 0;          // 0 idle, 1 cpu, 2 dma holding, 3 handing back
  int  m_age = 0;            // cycles DMA has held the bus so far (1-based)
  bit  m_owed = 0;           // CPU owed the next contention
  bit  m_cmd_done = 0;       // all_done seen during current hold
  bit  m_irq = 0, m_err = 0;
  int  n_timeouts = 0, n_irqs = 0;

  // Advance the model by one rising edge using the inputs held in the last cycle.
  task automatic model_edge();
    if (!reset_n) begin
      m_owner = 0; m_age = 0; m_owed = 0; m_cmd_done = 0; m_irq = 0; m_err = 0;
      return;
    end
    m_irq = 0;
    if (m_owner == 3) begin
      m_owner = 0; m_owed = 1; m_cmd_done = 0;
    end else if (m_owner == 2) begin
      if (dma_all_done) m_cmd_done = 1;
      if (dma_burst_done || m_age == MAX_HOLD || !dma_br) begin
        if (!dma_burst_done && m_age == MAX_HOLD) begin m_err = 1; n_timeouts++; end
        m_owner = 3; m_irq = m_cmd_done;
        if (m_irq) n_irqs++;
      end else m_age++;
    end else begin
      bit cpu_turn;
      cpu_turn = (m_owner == 1) ? 1'b1 : (cpu_mem_req && (m_owed || !dma_br));
      if (m_owner == 1 && cpu_mem_busy) begin
        // transaction in flight; bus stays with the CPU
      end else if (m_owner == 1 && dma_br) begin
        m_owner = 2; m_age = 1;
      end else if (m_owner == 1) begin
        m_owner = cpu_mem_req ? 1 : 0;
      end else if (cpu_turn) begin
        m_owner = 1; m_owed = 0;
      end else if (dma_br) begin
        m_owner = 2; m_age = 1;
      end else m_owed = 0;
    end
  endtask

  function automatic exp_t model_out();
    exp_t e;
    e.owner = m_owner;
    e.bg    = (m_owner == 2);
    e.cg    = (m_owner == 1) || (m_owner == 0 && cpu_mem_req && (m_owed || !dma_br));
    e.stall = cpu_mem_req && !e.cg;
    e.irq   = m_irq;
    e.terr  = m_err;
    return e;
  endfunction

  // One cycle: settle the model for the edge just taken, apply new inputs, queue expectation.
  task automatic step(bit rst, bit req, bit busy, bit br, bit bd, bit ad);
    @(posedge clk);
    #1;
    model_edge();
    reset_n = rst; cpu_mem_req = req; cpu_mem_busy = busy;
    dma_br = br; dma_burst_done = bd; dma_all_done = ad;
    sb.push_back(model_out());
  endtask

  task automatic idle_n(int n);
    for (int i = 0; i < n; i++) step(1, 0, 0, 0, 0, 0);
  endtask

  initial begin
    bit br_r, req_r, busy_r;
    reset_n = 0; cpu_mem_req = 1; cpu_mem_busy = 0; dma_br = 1;
    dma_burst_done = 0; dma_all_done = 0;

    // Reset with both requesters active, then release: DMA wins, CPU stalls.
    step(0, 1, 0, 1, 0, 0);
    step(0, 1, 0, 1, 0, 0);
    step(1, 1, 0, 1, 0, 0);
    step(1, 1, 0, 1, 0, 0);
    step(1, 1, 0, 1, 1, 0);
    step(1, 0, 0, 0, 0, 0);
    idle_n(3);

    // CPU busy for 3 cycles; DMA asks mid-transaction.
    step(1, 1, 1, 0, 0, 0);
    step(1, 1, 1, 1, 0, 0);
    step(1, 1, 1, 1, 0, 0);
    step(1, 1, 0, 1, 0, 0);
    for (int i = 0; i < 4; i++) step(1, 0, 0, 1, 0, 0);
    step(1, 1, 0, 1, 1, 0);
    // CPU request with DMA re-asserted: CPU is owed the bus after release.
    for (int i = 0; i < 4; i++) step(1, 1, 0, 1, 0, 0);
    step(1, 0, 0, 1, 0, 0);
    step(1, 0, 0, 1, 1, 0);
    idle_n(3);

    // Three bursts, all_done together with the third burst_done.
    for (int b = 0; b < 3; b++) begin
      step(1, 0, 0, 1, 0, 0);
      step(1, 0, 0, 1, 0, 0);
      step(1, 0, 0, 1, 1, (b == 2));
      step(1, 0, 0, 1, 0, 0);
    end
    idle_n(4);

    // burst_done coincides with the last watchdog cycle: no error.
    step(1, 0, 0, 1, 0, 0);
    for (int i = 0; i < MAX_HOLD - 1; i++) step(1, 0, 0, 1, 0, 0);
    step(1, 0, 0, 1, 1, 0);
    idle_n(3);

    // Hold without burst_done: forced release, sticky error.
    for (int i = 0; i < MAX_HOLD + 3; i++) step(1, 0, 0, 1, 0, 0);
    idle_n(6);
    step(0, 0, 0, 0, 0, 0);
    idle_n(2);

    // Randomized traffic with occasional resets.
    br_r = 0; req_r = 0; busy_r = 0;
    for (int i = 0; i < 4000; i++) begin
      bit rst, bd, ad;
      int bdp;
      bdp = (i < 2000) ? 4 : 14;
      rst = ($urandom_range(0, 399) != 0);
      if (br_r) br_r = ($urandom_range(0, 19) != 0);
      else      br_r = ($urandom_range(0, 3) == 0);
      req_r  = ($urandom_range(0, 2) != 0);
      busy_r = req_r && ($urandom_range(0, 2) == 0);
      bd = ($urandom_range(0, bdp - 1) == 0);
      ad = bd ? ($urandom_range(0, 2) == 0) : ($urandom_range(0, 29) == 0);
      step(rst, req_r, busy_r, br_r, bd, ad);
      if (bd && $urandom_range(0, 1) == 0) br_r = 0;
    end
    idle_n(2);

    @(posedge clk);
    #1;
    model_edge();
    begin : drain
      int guard = 0;
      while (sb.size() > 0 && guard < 20) begin
        @(negedge clk);
        guard++;
      end
      if (sb.size() > 0) begin
        failures++;
        checks++;
        $display("FAIL scoreboard_drain actual=%0d expected=0", sb.size());
      end
    end
    chk("timeouts_exercised", int'(n_timeouts > 0), 1);
    chk("irqs_exercised", int'(n_irqs > 0), 1);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
